// File: rtl/dt1_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dt1_ctrl_pkg
// Purpose  : Shared definitions for the RV32I decode stage.
//            - Control-word field widths and positions.
//            - CTRL_* constants.
//            - Opcode constants.
//            - Trap cause enum.
//            - decode(): a pure function returning {ctrl, cause}.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dt1_ctrl_pkg;

  localparam int CTRL_W  = 19;
  localparam int CAUSE_W = 2;

  // Field widths
  localparam int W_REGWR   = 1;
  localparam int W_IMMSRC  = 3;
  localparam int W_ALUASRC = 2;
  localparam int W_ALUBSRC = 1;
  localparam int W_MEMWR   = 2;
  localparam int W_RESSRC  = 2;
  localparam int W_BRANCH  = 1;
  localparam int W_ALUOP   = 2;
  localparam int W_JUMP    = 1;
  localparam int W_LS      = 3;
  localparam int W_PCTSRC  = 1;

  // Field LSB positions; RegWrite is the MSB and PCTargetALUSrc the LSB
  localparam int POS_PCTSRC  = 0;
  localparam int POS_LS      = POS_PCTSRC + W_PCTSRC;
  localparam int POS_JUMP    = POS_LS + W_LS;
  localparam int POS_ALUOP   = POS_JUMP + W_JUMP;
  localparam int POS_BRANCH  = POS_ALUOP + W_ALUOP;
  localparam int POS_RESSRC  = POS_BRANCH + W_BRANCH;
  localparam int POS_MEMWR   = POS_RESSRC + W_RESSRC;
  localparam int POS_ALUBSRC = POS_MEMWR + W_MEMWR;
  localparam int POS_ALUASRC = POS_ALUBSRC + W_ALUBSRC;
  localparam int POS_IMMSRC  = POS_ALUASRC + W_ALUASRC;
  localparam int POS_REGWR   = POS_IMMSRC + W_IMMSRC;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_ECALL   = 2'b10,
    CAUSE_EBREAK  = 2'b11
  } cause_e;

  typedef struct packed {
    ctrl_t  ctrl;
    cause_e cause;
  } dec_t;

  // Assembles a control word field by field so the constants below read
  // in the same order as the documented bit layout.
  function automatic ctrl_t mk_ctrl(
    input logic       rw,
    input logic [2:0] imm,
    input logic [1:0] asrc,
    input logic       bsrc,
    input logic [1:0] mw,
    input logic [1:0] res,
    input logic       br,
    input logic [1:0] aluop,
    input logic       jmp,
    input logic [2:0] ls,
    input logic       pct
  );
    ctrl_t c;
    c = '0;
    c[POS_REGWR   +: W_REGWR]   = rw;
    c[POS_IMMSRC  +: W_IMMSRC]  = imm;
    c[POS_ALUASRC +: W_ALUASRC] = asrc;
    c[POS_ALUBSRC +: W_ALUBSRC] = bsrc;
    c[POS_MEMWR   +: W_MEMWR]   = mw;
    c[POS_RESSRC  +: W_RESSRC]  = res;
    c[POS_BRANCH  +: W_BRANCH]  = br;
    c[POS_ALUOP   +: W_ALUOP]   = aluop;
    c[POS_JUMP    +: W_JUMP]    = jmp;
    c[POS_LS      +: W_LS]      = ls;
    c[POS_PCTSRC  +: W_PCTSRC]  = pct;
    return c;
  endfunction

  // LoadSize / MemWrite are zero in CTRL_LOAD / CTRL_STORE and filled in by decode()
  localparam ctrl_t CTRL_LOAD  = mk_ctrl(1'b1, 3'b000, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
  localparam ctrl_t CTRL_STORE = mk_ctrl(1'b0, 3'b001, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
  localparam ctrl_t CTRL_R     = mk_ctrl(1'b1, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0);
  localparam ctrl_t CTRL_B     = mk_ctrl(1'b0, 3'b010, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 3'b000, 1'b0);
  localparam ctrl_t CTRL_I     = mk_ctrl(1'b1, 3'b000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0);
  localparam ctrl_t CTRL_SH    = mk_ctrl(1'b1, 3'b100, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0);
  localparam ctrl_t CTRL_JAL   = mk_ctrl(1'b1, 3'b011, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0);
  localparam ctrl_t CTRL_LUI   = mk_ctrl(1'b1, 3'b101, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
  localparam ctrl_t CTRL_AUIPC = mk_ctrl(1'b1, 3'b101, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0);
  localparam ctrl_t CTRL_JALR  = mk_ctrl(1'b1, 3'b000, 2'b00, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1);

  localparam logic [6:0] OP_BUBBLE = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0]  F7_ZERO = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  function automatic dec_t decode(input logic [31:0] instr, input logic check_funct7);
    dec_t       d;
    logic       ok;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op      = instr[6:0];
    f3      = instr[14:12];
    f7      = instr[31:25];
    ok      = 1'b1;
    d.ctrl  = '0;
    d.cause = CAUSE_NONE;
    case (op)
      OP_BUBBLE: ;
      OP_LOAD: begin
        d.ctrl = CTRL_LOAD;
        case (f3)
          3'b010:  d.ctrl[POS_LS +: W_LS] = 3'b000; // lw
          3'b000:  d.ctrl[POS_LS +: W_LS] = 3'b001; // lb
          3'b100:  d.ctrl[POS_LS +: W_LS] = 3'b010; // lbu
          3'b001:  d.ctrl[POS_LS +: W_LS] = 3'b011; // lh
          3'b101:  d.ctrl[POS_LS +: W_LS] = 3'b100; // lhu
          default: ok = 1'b0;
        endcase
      end
      OP_STORE: begin
        d.ctrl = CTRL_STORE;
        case (f3)
          3'b010:  d.ctrl[POS_MEMWR +: W_MEMWR] = 2'b01; // sw
          3'b001:  d.ctrl[POS_MEMWR +: W_MEMWR] = 2'b10; // sh
          3'b000:  d.ctrl[POS_MEMWR +: W_MEMWR] = 2'b11; // sb
          default: ok = 1'b0;
        endcase
      end
      OP_RTYPE: begin
        d.ctrl = CTRL_R;
        // funct7 0100000 only exists for sub (000) and sra (101)
        if (check_funct7 && !((f7 == F7_ZERO) ||
            ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
          ok = 1'b0;
      end
      OP_BRANCH: begin
        d.ctrl = CTRL_B;
        if ((f3 == 3'b010) || (f3 == 3'b011)) ok = 1'b0;
      end
      OP_IALU: begin
        if (f3 == 3'b001) begin
          d.ctrl = CTRL_SH;
          if (check_funct7 && (f7 != F7_ZERO)) ok = 1'b0;
        end else if (f3 == 3'b101) begin
          d.ctrl = CTRL_SH;
          if (check_funct7 && (f7 != F7_ZERO) && (f7 != F7_ALT)) ok = 1'b0;
        end else begin
          d.ctrl = CTRL_I;
        end
      end
      OP_JAL:   d.ctrl = CTRL_JAL;
      OP_LUI:   d.ctrl = CTRL_LUI;
      OP_AUIPC: d.ctrl = CTRL_AUIPC;
      OP_JALR: begin
        d.ctrl = CTRL_JALR;
        if (f3 != 3'b000) ok = 1'b0;
      end
      OP_FENCE: begin
        if (f3 != 3'b000) ok = 1'b0;
      end
      OP_SYSTEM: begin
        if (instr == INSTR_ECALL)       d.cause = CAUSE_ECALL;
        else if (instr == INSTR_EBREAK) d.cause = CAUSE_EBREAK;
        else                            ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d.ctrl  = '0;
      d.cause = CAUSE_ILLEGAL;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dt1_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dt1_ctrl_fifo
// Purpose  : Generic DEPTH x W synchronous FIFO with a synchronous flush.
//            Read data is the head entry, forced to zero when empty.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            flush          - empties the FIFO; overrides push/pop
//            push_i, wdata_i- write request and data
//            pop_i          - read request
//            rdata_o        - head entry (0 when empty)
//            full_o, empty_o- occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module dt1_ctrl_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [W-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                w_do_push;
  logic                w_do_pop;

  assign full_o    = (count_q == CNT_BITS'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i && !full_o && !flush;
  assign w_do_pop  = pop_i && !empty_o && !flush;
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty entries are masked on the read side.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/dt1_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : dt1_decode_stage
// Purpose  : Registered, handshaked RV32I decode stage between fetch and
//            execute. Decodes at push time, buffers {ctrl, cause, instr, pc}
//            in a FIFO, halts intake on a trap until flushed, and keeps a
//            saturating illegal-instruction count.
// Ports    : clk, reset                    - clock, synchronous active-high reset
//            flush                         - empty FIFO, return to RUN
//            in_valid/in_ready/in_instr/in_pc - fetch-side handshake
//            out_valid/out_ready           - execute-side handshake
//            out_ctrl/out_instr/out_pc/out_cause - head entry (0 when empty)
//            halted                        - trap seen, waiting for flush
//            illegal_count                 - saturating illegal counter
// Revision : 1.0 - initial release
// ============================================================================
module dt1_decode_stage
  import dt1_ctrl_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int CHECK_FUNCT7 = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [18:0]      out_ctrl,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [1:0]       out_cause,
  output logic             halted,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int ENTRY_W = CTRL_W + CAUSE_W + 32 + 32;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   illegal_count_q, illegal_count_d;
  dec_t               w_dec;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_push_acc;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;

  assign w_dec      = decode(in_instr, CHECK_FUNCT7 != 0);
  assign in_ready   = !w_full && (state_q == ST_RUN);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  // A push coinciding with flush is discarded, so it must not trap or count.
  assign w_push_acc = w_push && !flush;
  assign w_wr_entry = {w_dec.ctrl, w_dec.cause, in_instr, in_pc};

  dt1_ctrl_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push_i  (w_push),
    .wdata_i (w_wr_entry),
    .pop_i   (w_pop),
    .rdata_o (w_rd_entry),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign out_valid = !w_empty;
  assign {out_ctrl, out_cause, out_instr, out_pc} = w_rd_entry;
  assign halted        = (state_q == ST_HALTED);
  assign illegal_count = illegal_count_q;

  always_comb begin
    state_d         = state_q;
    illegal_count_d = illegal_count_q;
    if (flush) begin
      state_d = ST_RUN;
    end else if (w_push_acc && (w_dec.cause != CAUSE_NONE)) begin
      state_d = ST_HALTED;
    end
    if (w_push_acc && (w_dec.cause == CAUSE_ILLEGAL) && (illegal_count_q != '1))
      illegal_count_d = illegal_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_RUN;
      illegal_count_q <= '0;
    end else begin
      state_q         <= state_d;
      illegal_count_q <= illegal_count_d;
    end
  end

endmodule
`default_nettype wire
